bit_serial_logic_unit: RTL
==========================

# bit_serial_logic_unit

Multi-cycle bitwise logic unit for the CPU datapath: accepts two WIDTH-bit operands and an opcode, evaluates the operation one bit per clock LSB-first through a single 1-bit gate cell, and reassembles the parallel result. It is the sequential, word-level counterpart of the single-bit logic gates. It serialises operands into the gate and deserialises the gate output back into a word. It sits beside the ALU and is driven by the control unit through a start/busy/done handshake.

## Interface
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when the unit can accept
- op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NAND
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- busy  output  1  high while bits are being evaluated
- done  output  1  one-cycle pulse; result valid
- result  output  WIDTH  last completed result, held until next completion
- zero  output  1  high when result == 0

## Operation
- States: IDLE, RUN, DONE.
- IDLE: if start=1, latch a, b and op into shift registers and an op register. Clear the bit counter. Go to RUN.
- RUN:
  - Each cycle, the gate cell computes op(sa[0], sb[0]).
  - Shift sa and sb right by one.
  - Shift the cell output into the MSB of the result shift register, so the bit arrives at its correct position after WIDTH shifts.
  - Increment the counter.
  - After the WIDTH-th bit, go to DONE.
- DONE:
  - Copy the result shift register to result.
  - Set zero = (shift register == 0).
  - Assert done for this cycle only.
  - If start=1 in this cycle, latch the new operands and go directly to RUN (back-to-back). Otherwise go to IDLE.
- start in RUN is ignored; the latched operands and op are not disturbed.
- Changes on a, b and op after acceptance have no effect.
- result and zero update only in DONE. They are stable at all other times.
- Counter width is $clog2(WIDTH+1). No arithmetic carries; bits are independent.
- Reset (asynchronous, any state, including mid-RUN):
  - state = IDLE, busy = 0, done = 0.
  - result = 0, zero = 1.
  - Shift registers and counter cleared.
  - A discarded operation never produces a done pulse.

## Timing
- Start accepted at edge 0 (state IDLE or DONE).
- busy = 1 for exactly WIDTH cycles, after edges 1..WIDTH. busy is a registered state decode: busy = (state == RUN).
- done = 1 for one cycle after edge WIDTH+1. result and zero are valid in that same cycle.
- Latency from accepted start to done: WIDTH+1 cycles.
- Throughput with back-to-back starts: one result per WIDTH+1 cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- start while rst=1 is lost.

## Structure
- Shared package/header cpu_logic_pkg holds:
  - the op encodings (OP_AND, OP_OR, OP_XOR, OP_NAND);
  - the state encoding (ST_IDLE, ST_RUN, ST_DONE).
- Sub-module logic_bit_cell: purely combinational 1-bit evaluator, inputs x, y, op, output z. It is reused by any future serial datapath units.
- Top level contains the FSM, counter, operand shift registers, result shift register and output registers.

## Test plan
All cases use WIDTH = 8.
- AND: a=8'hF0, b=8'h3C, op=00, start for 1 cycle -> busy for 8 cycles, done in 9th cycle after acceptance, result=8'h30, zero=0.
- XOR zero flag: a=b=8'hA5, op=10 -> result=8'h00, zero=1 on done, held afterwards.
- Start while busy: accept a=8'h0F, b=8'hFF, op=01. At cycle 3 drive start with a=8'h00, b=8'h00 -> single done, result=8'hFF, no second operation.
- Back-to-back: hold start=1 with NAND, a=8'hFF, b=8'h0F, then OR, a=8'h01, b=8'h80 -> done pulses at cycles 9 and 18 with result=8'hF0, then 8'h81. busy low only during DONE cycles.
- Reset mid-RUN: assert rst at cycle 4 of an AND with result previously 8'h30 -> busy, done and result drop to 0 asynchronously, zero=1, no done pulse. A subsequent start completes normally.
- Reset defaults: after power-up rst -> busy=0, done=0, result=8'h00, zero=1. start held low -> outputs unchanged for 20 cycles.

Source files
------------

// File: rtl/cpu_logic_pkg.sv
// Shared encodings for the serial logic datapath: gate opcodes and the
// sequencer state used by bit_serial_logic_unit.
package cpu_logic_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/logic_bit_cell.sv
// Purely combinational 1-bit logic evaluator shared by the serial datapath units.
module logic_bit_cell
  import cpu_logic_pkg::*;
(
  input  logic       x,
  input  logic       y,
  input  logic [1:0] op,
  output logic       z
);

  always_comb begin
    z = 1'b0;
    case (op)
      OP_AND:  z = x & y;
      OP_OR:   z = x | y;
      OP_XOR:  z = x ^ y;
      OP_NAND: z = ~(x & y);
      default: z = 1'b0;
    endcase
  end

endmodule

// File: rtl/bit_serial_logic_unit.sv
// Word-level logic unit that evaluates one bit per clock LSB-first through a
// single logic_bit_cell and reassembles the result behind a start/busy/done handshake.
module bit_serial_logic_unit
  import cpu_logic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic             w_load;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sr;
  op_e              r_op;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             w_z;
  logic [WIDTH-1:0] w_sr_shifted;
  logic             w_last;

  logic_bit_cell u_cell (
    .x  (r_sa[0]),
    .y  (r_sb[0]),
    .op (r_op),
    .z  (w_z)
  );

  // The cell output enters at the MSB so bit i lands at position i after WIDTH shifts.
  assign w_sr_shifted = {w_z, r_sr[WIDTH-1:1]};
  assign w_last       = (r_cnt == LAST_BIT);

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sa     <= '0;
      r_sb     <= '0;
      r_sr     <= '0;
      r_op     <= OP_AND;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b1;
    end else if (w_load) begin
      r_sa  <= a;
      r_sb  <= b;
      r_sr  <= '0;
      r_op  <= op_e'(op);
      r_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_sa  <= r_sa >> 1;
      r_sb  <= r_sb >> 1;
      r_sr  <= w_sr_shifted;
      r_cnt <= r_cnt + 1'b1;
      // Output registers load on the final bit so they are valid throughout DONE.
      if (w_last) begin
        r_result <= w_sr_shifted;
        r_zero   <= (w_sr_shifted == '0);
      end
    end
  end

  assign busy   = (r_state == ST_RUN);
  assign done   = (r_state == ST_DONE);
  assign result = r_result;
  assign zero   = r_zero;

endmodule
